fxp_conv_arbiter: RTL and testbench

- Shares one fixed-point format-conversion datapath among N_REQ requesters.
- Each requester presents a sign+int+mant word over valid/ready.
- A round-robin arbiter selects one requester per accepted transfer. A 2-stage pipeline converts the word to the output format and emits it tagged with the requester ID.
- Sits between parallel filter-lane outputs and the common downstream accumulator/serialiser of the control-bounded filter.

---
 rtl/fxp_conv_arbiter.sv | 133 +++++++++++++
 tb/tb_fxp_conv_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_conv_arbiter.sv
// Round-robin arbiter feeding one shared two-stage fixed-point format converter.
// Each emitted word carries the index of the requester it came from.
module fxp_conv_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_INT_IN   = 8,
  parameter int N_MANT_IN  = 23,
  parameter int N_INT_OUT  = 8,
  parameter int N_MANT_OUT = 23,
  parameter bit SATURATE   = 1'b1,
  localparam int W_IN  = N_INT_IN + N_MANT_IN + 1,
  localparam int W_OUT = N_INT_OUT + N_MANT_OUT + 1,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       in_valid,
  output logic [N_REQ-1:0]       in_ready,
  input  logic [N_REQ*W_IN-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W_OUT-1:0]       out_data,
  output logic [IDW-1:0]         out_id,
  output logic                   out_ovf,
  output logic                   ovf_sticky
);

  localparam int unsigned NR = N_REQ;
  localparam int D  = N_MANT_OUT - N_MANT_IN;
  localparam int SL = (D > 0) ? D : 0;
  localparam int SR = (D < 0) ? -D - 1 : 0;
  // Headroom covers the full left-shifted input as well as the rounding increment.
  localparam int WI = (((W_IN + SL) > W_OUT) ? (W_IN + SL) : W_OUT) + 2;
  localparam logic signed [WI-1:0] ONE  = WI'(1);
  localparam logic signed [WI-1:0] MAXV = (ONE <<< (W_OUT - 1)) - ONE;
  localparam logic signed [WI-1:0] MINV = ~MAXV;

  logic              s1_valid_q;
  logic [W_IN-1:0]   s1_data_q;
  logic [IDW-1:0]    s1_id_q;
  logic [IDW-1:0]    last_q;
  logic              out_valid_q;
  logic [W_OUT-1:0]  out_data_q;
  logic [IDW-1:0]    out_id_q;
  logic              out_ovf_q;
  logic              ovf_sticky_q;

  logic              adv1, adv2, take;
  logic              grant_found_d;
  logic [IDW-1:0]    grant_d;
  int unsigned       cand;
  logic signed [WI-1:0] x, r, y;
  logic [W_OUT-1:0]  conv_d;
  logic              ovf_d;

  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  assign take = grant_found_d && adv1;

  always_comb begin
    grant_found_d = 1'b0;
    grant_d       = '0;
    cand          = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = (32'(last_q) + k) % NR;
      if (!grant_found_d && in_valid[IDW'(cand)]) begin
        grant_found_d = 1'b1;
        grant_d       = IDW'(cand);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant_d] = 1'b1;
  end

  always_comb begin
    x = {{(WI - W_IN){s1_data_q[W_IN-1]}}, s1_data_q};
    r = '0;
    if (D > 0) begin
      y = x <<< SL;
    end else if (D < 0) begin
      // Round half up: drop all but one guard bit, add one, drop the guard bit.
      r = (x >>> SR) + ONE;
      y = r >>> 1;
    end else begin
      y = x;
    end
    ovf_d = (y > MAXV) || (y < MINV);
    if (SATURATE && (y > MAXV))      conv_d = MAXV[W_OUT-1:0];
    else if (SATURATE && (y < MINV)) conv_d = MINV[W_OUT-1:0];
    else                             conv_d = y[W_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_id_q      <= '0;
      last_q       <= IDW'(NR - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= take;
        if (take) begin
          s1_data_q <= in_data[32'(grant_d) * W_IN +: W_IN];
          s1_id_q   <= grant_d;
          last_q    <= grant_d;
        end
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= conv_d;
          out_id_q   <= s1_id_q;
          out_ovf_q  <= ovf_d;
        end
      end
      if (out_valid_q && out_ready && out_ovf_q) ovf_sticky_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fxp_conv_arbiter.sv
// Scoreboard bench: three converter configurations share one request stream
// (round/saturate, round/wrap, exact left shift) and are checked word by word.
module tb_fxp_conv_arbiter;
  localparam int NR  = 4;
  localparam int WIN = 13;
  localparam int WO  = 9;
  localparam int WOS = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     in_valid = '0;
  logic [NR*WIN-1:0] in_data = '0;
  logic              out_ready = 1'b1;

  logic [NR-1:0]  rdy_a, rdy_b, rdy_c;
  logic           ov_a, ov_b, ov_c;
  logic [WO-1:0]  od_a, od_b;
  logic [WOS-1:0] od_c;
  logic [1:0]     id_a, id_b, id_c;
  logic           of_a, of_b, of_c;
  logic           st_a, st_b, st_c;

  always #5 clk = ~clk;

  fxp_conv_arbiter #(.N_REQ(4), .N_INT_IN(4), .N_MANT_IN(8), .N_INT_OUT(4),
                     .N_MANT_OUT(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_id(id_a),
    .out_ovf(of_a), .ovf_sticky(st_a));

  fxp_conv_arbiter #(.N_REQ(4), .N_INT_IN(4), .N_MANT_IN(8), .N_INT_OUT(4),
                     .N_MANT_OUT(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_id(id_b),
    .out_ovf(of_b), .ovf_sticky(st_b));

  fxp_conv_arbiter #(.N_REQ(4), .N_INT_IN(4), .N_MANT_IN(8), .N_INT_OUT(4),
                     .N_MANT_OUT(12), .SATURATE(1'b1)) u_shl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_id(id_c),
    .out_ovf(of_c), .ovf_sticky(st_c));

  typedef struct {
    int id;
    int d_sat;
    int d_wrap;
    int d_shl;
    bit ovf;
    bit ovf_shl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_m = NR - 1;
  int   g;
  exp_t e;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int conv_ref(input int x, input int mo, input int wo, input bit sat,
                                  output bit ovf);
    int d, t, hi, lo;
    d = mo - 8;
    if (d >= 0) t = x * (1 << d);
    else        t = (x + (1 << (-d - 1))) >>> (-d);
    hi  = (1 << (wo - 1)) - 1;
    lo  = -(1 << (wo - 1));
    ovf = (t > hi) || (t < lo);
    if (!ovf) return t;
    if (sat) return (t > hi) ? hi : lo;
    t = t & ((1 << wo) - 1);
    return (t > hi) ? t - (1 << wo) : t;
  endfunction

  function automatic exp_t mk(input int id, input logic [WIN-1:0] raw);
    exp_t r;
    bit   o1, o2, o3;
    int   x;
    x         = int'($signed(raw));
    r.id      = id;
    r.d_sat   = conv_ref(x, 4, WO, 1'b1, o1);
    r.d_wrap  = conv_ref(x, 4, WO, 1'b0, o2);
    r.d_shl   = conv_ref(x, 12, WOS, 1'b1, o3);
    r.ovf     = o1;
    r.ovf_shl = o3;
    return r;
  endfunction

  function automatic int pred_grant(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Monitor: predicts grants, pushes expectations on transfer, pops on output.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_m = NR - 1;
    end else begin
      if (rdy_a != '0) begin
        g = pred_grant(in_valid, last_m);
        check_eq("in_ready", int'(rdy_a), (g < 0) ? 0 : (1 << g));
        check_eq("in_ready_wrap", int'(rdy_b), (g < 0) ? 0 : (1 << g));
        check_eq("in_ready_shl", int'(rdy_c), (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
          sb.push_back(mk(g, in_data[g*WIN +: WIN]));
          last_m = g;
        end
      end
      if (ov_a && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("out_without_input", int'(ov_a), 0);
        end else begin
          e = sb.pop_front();
          check_eq("out_id", int'(id_a), e.id);
          check_eq("out_data_sat", int'($signed(od_a)), e.d_sat);
          check_eq("out_ovf_sat", int'(of_a), int'(e.ovf));
          check_eq("out_valid_wrap", int'(ov_b), 1);
          check_eq("out_data_wrap", int'($signed(od_b)), e.d_wrap);
          check_eq("out_ovf_wrap", int'(of_b), int'(e.ovf));
          check_eq("out_valid_shl", int'(ov_c), 1);
          check_eq("out_id_shl", int'(id_c), e.id);
          check_eq("out_data_shl", int'($signed(od_c)), e.d_shl);
          check_eq("out_ovf_shl", int'(of_c), int'(e.ovf_shl));
        end
      end
    end
  end

  task automatic step();
    logic [NR-1:0] r;
    @(negedge clk) r = rdy_a;
    @(posedge clk);
    #1 in_valid = in_valid & ~r;
  endtask

  task automatic drain_inputs();
    int n = 0;
    while (in_valid != '0 && n < 60) begin
      step();
      n++;
    end
    check_eq("inputs_accepted", int'(in_valid), 0);
  endtask

  task automatic send(input int id, input int val);
    in_data[id*WIN +: WIN] = WIN'(val);
    in_valid[id] = 1'b1;
    drain_inputs();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NR; i++) in_data[i*WIN +: WIN] = WIN'($urandom);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", int'(ov_a), 0);
    check_eq("rst_out_data", int'(od_a), 0);
    check_eq("rst_out_id", int'(id_a), 0);
    check_eq("rst_out_ovf", int'(of_a), 0);
    check_eq("rst_sticky", int'(st_a), 0);
    check_eq("rst_in_ready", int'(rdy_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Rounding and two-cycle latency
    in_data[0 +: WIN] = WIN'(24);
    in_valid = 4'b0001;
    @(negedge clk) check_eq("lat_in_ready", int'(rdy_a), 1);
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk) check_eq("lat_cycle1_valid", int'(ov_a), 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_cycle2_valid", int'(ov_a), 1);
    check_eq("round_24", int'($signed(od_a)), 2);
    check_eq("round_24_id", int'(id_a), 0);
    check_eq("round_24_ovf", int'(of_a), 0);
    @(posedge clk);
    #1;
    send(0, -24);
    send(0, 23);
    send(0, 40);
    send(0, 3);
    @(posedge clk);
    @(negedge clk);
    check_eq("shl_3", int'($signed(od_c)), 48);
    check_eq("shl_3_ovf", int'(of_c), 0);
    check_eq("round_3", int'($signed(od_a)), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) check_eq("sticky_clear", int'(st_a), 0);

    // Saturation versus wrap
    @(posedge clk);
    #1 send(2, 4095);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_4095", int'($signed(od_a)), 255);
    check_eq("sat_4095_ovf", int'(of_a), 1);
    check_eq("sat_4095_id", int'(id_a), 2);
    check_eq("wrap_4095", int'($signed(od_b)), -256);
    check_eq("wrap_4095_ovf", int'(of_b), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("sticky_sat", int'(st_a), 1);
    check_eq("sticky_wrap", int'(st_b), 1);
    check_eq("sticky_shl", int'(st_c), 0);
    @(posedge clk);
    #1 send(2, -4096);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_m4096", int'($signed(od_a)), -256);
    @(posedge clk);
    #1 pulse_reset();

    // Round-robin under full load
    fill_random();
    in_valid = '1;
    fork
      begin
        repeat (8) @(posedge clk);
        #1 in_valid = '0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!ov_a && n < 10) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          check_eq("rr_valid", int'(ov_a), 1);
          check_eq("rr_id", int'(id_a), k % NR);
          if (k < 7) @(negedge clk);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: one word held at the output, one parked in stage 1
    out_ready = 1'b0;
    fill_random();
    e = mk(0, in_data[0 +: WIN]);
    in_valid = '1;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_valid", int'(ov_a), 1);
      check_eq("bp_id", int'(id_a), 0);
      check_eq("bp_data", int'($signed(od_a)), e.d_sat);
      check_eq("bp_in_ready", int'(rdy_a), 0);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    drain_inputs();
    repeat (5) @(posedge clk);
    check_eq("bp_drained", sb.size(), 0);

    // Reset with both stages occupied and the pointer parked on requester 0
    #1;
    send(0, 1000);
    in_data[0 +: WIN] = WIN'(-4000);
    out_ready = 1'b0;
    in_valid = 4'b0001;
    step();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_valid", int'(ov_a), 0);
    check_eq("midrst_sticky", int'(st_a), 0);
    check_eq("midrst_in_ready", int'(rdy_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    fill_random();
    in_valid = 4'b0011;
    @(negedge clk) check_eq("midrst_first_grant", int'(rdy_a), 1);
    drain_inputs();
    repeat (5) @(posedge clk);
    check_eq("midrst_drained", sb.size(), 0);

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      #1;
      fill_random();
      in_valid  = NR'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
    end
    #1;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    check_eq("random_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
